// File: rtl/nn_pkg.sv
// Shared definitions for the neuron feeder: data width, config map and default neuron latency.
package nn_pkg;

    localparam int DW             = 16;
    localparam int NEURON_LAT_DEF = 3;

    typedef enum logic [2:0] {
        CFG_W1    = 3'd0,
        CFG_W2    = 3'd1,
        CFG_W3    = 3'd2,
        CFG_W4    = 3'd3,
        CFG_SIGMA = 3'd4
    } cfg_addr_e;

endpackage

// File: rtl/nn_result_fifo.sv
// First-word-fall-through result buffer; a push into a full FIFO succeeds when a pop frees the slot.
module nn_result_fifo
    import nn_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DW,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/neuron_feeder.sv
// Groups four samples into a vector for one neuron, tracks its fixed latency and
// returns each thresholded result through a credit-protected result FIFO.
module neuron_feeder
    import nn_pkg::*;
#(
    parameter int NEURON_LAT = NEURON_LAT_DEF,
    parameter int RES_DEPTH  = 4,
    parameter int DW         = nn_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          cfg_err,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] nx1,
    output logic [DW-1:0] nx2,
    output logic [DW-1:0] nx3,
    output logic [DW-1:0] nx4,
    output logic [DW-1:0] nw1,
    output logic [DW-1:0] nw2,
    output logic [DW-1:0] nw3,
    output logic [DW-1:0] nw4,
    output logic [DW-1:0] nsigma,
    input  logic [DW-1:0] ny,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy
);

    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [1:0]          idx;
    logic [DW-1:0]       slot0;
    logic [DW-1:0]       slot1;
    logic [DW-1:0]       slot2;
    logic [NEURON_LAT:0] pipe;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic [7:0]          occupancy;
    logic                credit_ok;
    logic                accept;
    logic                issue;
    logic                cfg_bad;

    function automatic logic [7:0] ones(input logic [NEURON_LAT:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i <= NEURON_LAT; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // Every vector in the neuron already owns a FIFO slot, so results can never be lost.
    assign occupancy = ones(pipe) + 8'(fifo_count);
    assign credit_ok = !fifo_full && (occupancy < 8'(RES_DEPTH));
    assign s_ready   = (idx != 2'd3) || credit_ok;
    assign accept    = s_valid && s_ready;
    assign issue     = accept && (idx == 2'd3);
    assign busy      = (|pipe) || !fifo_empty || (idx != 2'd0);
    assign m_valid   = !fifo_empty;
    assign cfg_bad   = busy || (cfg_addr > CFG_SIGMA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            slot0 <= '0;
            slot1 <= '0;
            slot2 <= '0;
            nx1   <= '0;
            nx2   <= '0;
            nx3   <= '0;
            nx4   <= '0;
            pipe  <= '0;
        end else begin
            pipe <= {pipe[NEURON_LAT-1:0], issue};
            if (accept) begin
                idx <= idx + 2'd1;
                case (idx)
                    2'd0: slot0 <= s_data;
                    2'd1: slot1 <= s_data;
                    2'd2: slot2 <= s_data;
                    default: begin
                        nx1 <= slot0;
                        nx2 <= slot1;
                        nx3 <= slot2;
                        nx4 <= s_data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nw1     <= '0;
            nw2     <= '0;
            nw3     <= '0;
            nw4     <= '0;
            nsigma  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && cfg_bad;
            if (cfg_we && !cfg_bad) begin
                case (cfg_addr)
                    CFG_W1:    nw1    <= cfg_wdata;
                    CFG_W2:    nw2    <= cfg_wdata;
                    CFG_W3:    nw3    <= cfg_wdata;
                    CFG_W4:    nw4    <= cfg_wdata;
                    CFG_SIGMA: nsigma <= cfg_wdata;
                    default:   ;
                endcase
            end
        end
    end

    nn_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pipe[NEURON_LAT]),
        .wdata (ny),
        .pop   (m_ready),
        .rdata (m_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: a 3-stage neuron model drives ny, and a queue-based
// reference predicts every result from the samples and weights the bench has sent.
module tb_neuron_feeder;
    import nn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic        cfg_err;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] nx1, nx2, nx3, nx4, nw1, nw2, nw3, nw4, nsigma;
    logic [15:0] ny = '0;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int npop   = 0;

    logic [15:0] mw [4];
    logic [15:0] msig;
    logic [15:0] stage [3];
    int          nsamp;
    logic [15:0] exp_q [$];
    logic        rand_ready = 1'b0;

    always #5 clk = ~clk;

    neuron_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .nx1(nx1), .nx2(nx2), .nx3(nx3), .nx4(nx4),
        .nw1(nw1), .nw2(nw2), .nw3(nw3), .nw4(nw4), .nsigma(nsigma),
        .ny(ny), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    // Neuron behaviour: sum of (x*w)>>16, passed through only when it reaches sigma.
    function automatic logic [15:0] neuron_fn(
        input logic [15:0] x1, x2, x3, x4, w1, w2, w3, w4, sg);
        logic [31:0] s;
        s = ((32'(x1) * 32'(w1)) >> 16) + ((32'(x2) * 32'(w2)) >> 16)
          + ((32'(x3) * 32'(w3)) >> 16) + ((32'(x4) * 32'(w4)) >> 16);
        return (s >= 32'(sg)) ? s[15:0] : 16'h0000;
    endfunction

    logic [15:0] st1 = '0;
    logic [15:0] st2 = '0;
    always @(posedge clk) begin
        st1 <= neuron_fn(nx1, nx2, nx3, nx4, nw1, nw2, nw3, nw4, nsigma);
        st2 <= st1;
        ny  <= st2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            npop++;
            if (exp_q.size() == 0) chk("unexpected_result", 32'(m_valid), 32'd0);
            else chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mw[i] = '0;
        msig  = '0;
        nsamp = 0;
        exp_q.delete();
    endtask

    task automatic chk_regs();
        chk("nw1", 32'(nw1), 32'(mw[0]));
        chk("nw2", 32'(nw2), 32'(mw[1]));
        chk("nw3", 32'(nw3), 32'(mw[2]));
        chk("nw4", 32'(nw4), 32'(mw[3]));
        chk("nsigma", 32'(nsigma), 32'(msig));
    endtask

    task automatic cfg(input logic [2:0] addr, input logic [15:0] data);
        logic drop;
        drop = (nsamp != 0) || (exp_q.size() != 0) || (addr > 3'd4);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        if (!drop) begin
            if (addr == 3'd4) msig = data;
            else mw[addr[1:0]] = data;
        end
        @(negedge clk);
        chk("cfg_err", 32'(cfg_err), 32'(drop));
        chk_regs();
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        @(negedge clk);
        s_data = d; s_valid = 1'b1;
        t = 0;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("s_ready_wait", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 s_valid = 1'b0;
            if (nsamp < 3) begin
                stage[nsamp] = d;
                nsamp++;
            end else begin
                exp_q.push_back(neuron_fn(stage[0], stage[1], stage[2], d,
                                          mw[0], mw[1], mw[2], mw[3], msig));
                nsamp = 0;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int p0;
        int seen;
        logic [15:0] bp [24];

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_nx1", 32'(nx1), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk_regs();
        rst_n = 1'b1;

        // basic result with exact latency
        for (int i = 0; i < 4; i++) cfg(3'(i), 16'h0100);
        cfg(3'd4, 16'h0002);
        p0 = npop;
        for (int i = 0; i < 4; i++) send(16'h0100);
        @(negedge clk);
        chk("nx1", 32'(nx1), 32'h0100);
        chk("nx2", 32'(nx2), 32'h0100);
        chk("nx3", 32'(nx3), 32'h0100);
        chk("nx4", 32'(nx4), 32'h0100);
        chk("m_valid_e0", 32'(m_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("m_valid_early", 32'(m_valid), 32'd0);
        end
        @(negedge clk);
        chk("m_valid_lat4", 32'(m_valid), 32'd1);
        chk("m_data_basic", 32'(m_data), 32'h0004);
        @(negedge clk);
        chk("busy_after_pop", 32'(busy), 32'd0);
        chk("m_valid_after_pop", 32'(m_valid), 32'd0);
        chk("basic_count", 32'(npop - p0), 32'd1);

        // below threshold
        cfg(3'd4, 16'h0010);
        p0 = npop;
        for (int i = 0; i < 4; i++) send(16'h0100);
        wait_idle();
        chk("below_count", 32'(npop - p0), 32'd1);

        // backpressure: four results buffered, fifth vector held at idx 3
        cfg(3'd4, 16'h0002);
        @(posedge clk);
        #1 m_ready = 1'b0;
        p0 = npop;
        for (int i = 0; i < 24; i++) bp[i] = 16'(i * 16'h0a00 + 16'h0100);
        for (int i = 0; i < 19; i++) send(bp[i]);
        @(negedge clk);
        s_data = bp[19]; s_valid = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (s_ready) seen++;
        end
        chk("bp_s_ready_low", 32'(seen), 32'd0);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_no_pop", 32'(npop - p0), 32'd0);
        @(posedge clk);
        #1 m_ready = 1'b1;
        for (int i = 19; i < 24; i++) send(bp[i]);
        wait_idle();
        chk("bp_count", 32'(npop - p0), 32'd6);

        // config lockout while a vector is in flight
        p0 = npop;
        for (int i = 0; i < 4; i++) send(16'h0100);
        cfg(3'd4, 16'h0010);
        @(negedge clk);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd0);
        wait_idle();
        chk("lock_count", 32'(npop - p0), 32'd1);
        cfg(3'd6, 16'h1234);

        // partial vector discarded by reset
        send(16'h7777);
        send(16'h7777);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_m_valid", 32'(m_valid), 32'd0);
        chk_regs();
        for (int i = 0; i < 4; i++) cfg(3'(i), 16'h0200);
        cfg(3'd4, 16'h0001);
        p0 = npop;
        for (int i = 0; i < 4; i++) send(16'h0300);
        wait_idle();
        chk("fresh_count", 32'(npop - p0), 32'd1);

        // randomized streaming with random backpressure
        p0 = npop;
        for (int v = 0; v < 40; v++) begin
            if (v % 8 == 0) begin
                rand_ready = 1'b0;
                @(posedge clk);
                #2 m_ready = 1'b1;
                wait_idle();
                for (int i = 0; i < 4; i++) cfg(3'(i), 16'($urandom));
                cfg(3'd4, 16'($urandom_range(0, 16'h8000)));
                rand_ready = 1'b1;
            end
            for (int i = 0; i < 4; i++) send(16'($urandom));
        end
        @(posedge clk);
        #2;
        rand_ready = 1'b0;
        m_ready = 1'b1;
        wait_idle();
        chk("rand_count", 32'(npop - p0), 32'd40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Initiator and collector for a single `neuron` instance.
- Accepts a serial stream of 16-bit input samples and groups each four samples into one vector.
- Drives the vector, the stored weights and the threshold onto the neuron's input ports.
- Tracks the neuron's fixed pipeline latency and returns each thresholded result on a valid/ready output stream.
- Sits between the sample source (DMA/host) and the neuron array.

Parameters:
- NEURON_LAT, 3, number of register stages inside the neuron from its x/w inputs to y.
- RES_DEPTH, 4, result FIFO depth; also the maximum number of vectors in flight plus buffered results.
- DW, 16, data width of samples, weights, sigma and y.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  3  0..3 = w1..w4, 4 = sigma, 5..7 reserved.
- cfg_wdata  in  DW  configuration write data.
- cfg_err  out  1  one-cycle pulse when a write is dropped.
- s_data  in  DW  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- nx1..nx4  out  DW each  neuron x1..x4 drive.
- nw1..nw4  out  DW each  neuron w1..w4 drive.
- nsigma  out  DW  neuron sigma drive.
- ny  in  DW  neuron y.
- m_data  out  DW  result.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid && m_ready.
- busy  out  1  high while any vector is in flight or any result is buffered.

Behaviour:
- Reset (async assert, sync release):
  - nx*, nw*, nsigma, m_data, cfg_err = 0.
  - m_valid = 0, busy = 0.
  - Sample index = 0, in-flight pipe cleared, FIFO emptied.
  - s_ready = 1 after reset.
- Config:
  - Writes to 0..4 update nw*/nsigma at the write edge, but only when busy = 0.
  - A write while busy = 1, or to addr 5..7, is dropped; cfg_err pulses high the next cycle.
  - Register values are stable for the whole lifetime of any in-flight vector.
- Sample assembly:
  - 2-bit index idx selects the staging slot.
  - Accepted samples fill slots 0,1,2 in order.
  - The 4th accepted sample loads nx1..nx4 together, from slots 0..2 plus s_data, at that edge (E0), wraps idx to 0, and pushes a 1 into the in-flight shift register.
  - nx* change only at issue edges; they hold between issues.
- Flow control:
  - credit_ok = (inflight_count + fifo_count) < RES_DEPTH.
  - s_ready = (idx != 3) || credit_ok.
  - A vector is never issued without a guaranteed FIFO slot, so no result is ever lost.
  - Back-to-back issue every 4 accepted samples is allowed.
- Latency tracking:
  - The in-flight shift register is NEURON_LAT+1 bits long.
  - When its last bit is set at edge E0+NEURON_LAT+1 (E4 at default), ny is written into the FIFO.
  - m_valid rises in the cycle after E4.
  - Minimum latency is 4 cycles from the 4th-sample handshake edge to m_valid.
- Output:
  - FIFO is first-word-fall-through; m_data = head, m_valid = !empty.
  - Simultaneous FIFO write and pop in the same cycle is legal, including when the FIFO is full (pop frees the slot).
  - m_data holds while m_valid && !m_ready.
- busy = |inflight_pipe || fifo_count != 0 || idx != 0.
- A partial vector (idx != 0) blocks config writes.
- Reset mid-operation discards partial vectors, in-flight entries and buffered results; no stale m_valid after release.

Decomposition:
- Shared package `nn_pkg`:
  - DW.
  - Config address constants CFG_W1..CFG_W4 = 0..3, CFG_SIGMA = 4.
  - Default NEURON_LAT.
- One sub-module `nn_result_fifo`:
  - Parameterised depth and width, FWFT.
  - Outputs count, full and empty.
  - Async active-low reset.
- Everything else stays in neuron_feeder.

Test Plan:
- Basic result (bench uses a cycle-accurate neuron model with NEURON_LAT = 3):
  - Stimulus: reset; write w1..w4 = 0x0100, sigma = 0x0002; stream 0x0100 x4 with m_ready = 1.
  - Response: nx1..nx4 = 0x0100 after the 4th handshake; m_valid high exactly 4 cycles later with m_data = 0x0004; busy falls the cycle after the pop.
- Below threshold:
  - Stimulus: sigma = 0x0010, same samples.
  - Response: m_data = 0x0000, m_valid still asserted once.
- Backpressure:
  - Stimulus: m_ready = 0; stream 24 samples continuously.
  - Response: exactly 4 results buffered; s_ready low at idx = 3 thereafter; no FIFO overflow.
  - Then m_ready = 1: all 6 results emerge in order; nothing dropped.
- Config lockout:
  - Stimulus: write sigma while one vector is in flight.
  - Response: cfg_err pulses 1 cycle; nsigma unchanged; the result uses the old sigma.
- Partial vector and reset:
  - Stimulus: stream 2 samples, assert rst_n = 0 for 1 cycle, then send 4 fresh samples.
  - Response: exactly one result, computed only from the fresh samples; m_valid = 0 during and right after reset.
- Simultaneous push and pop:
  - Stimulus: FIFO full and m_ready = 1 in the same cycle as a capture edge.
  - Response: count stays 4; order preserved.
